imm_ext_pipe: RTL and testbench

- Parametrised, pipelined immediate-extension stage for the pipelined MIPS datapath.
- Sits between instruction decode and the ID/EX register.
- Extends an IN_W-bit immediate to OUT_W bits in one of four modes: sign, zero, upper (LUI) and branch-offset.
- Results leave through a valid/ready interface backed by a 2-entry skid buffer, so backpressure from EX never creates a combinational ready path.

---
 rtl/imm_ext_pipe.sv | 128 ++++++++++++
 tb/tb_imm_ext_pipe.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_ext_pipe.sv
// Immediate-extension stage for the pipelined MIPS datapath: extends a raw
// immediate in sign/zero/upper/branch mode and buffers it behind a 2-entry skid.
module imm_ext_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       mode_i,
    input  logic [IN_W-1:0]  data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] data_o
);

    generate
        if (OUT_W < IN_W + 2) begin : g_bad_width
            $error("imm_ext_pipe: OUT_W must be at least IN_W+2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    function automatic logic [OUT_W-1:0] extend(input logic [1:0] mode,
                                                input logic [IN_W-1:0] imm);
        logic signed [IN_W-1:0]  imm_s;
        logic signed [OUT_W-1:0] sext;
        imm_s = imm;
        sext  = OUT_W'(imm_s);
        case (mode)
            2'b00:   extend = sext;
            2'b01:   extend = {{(OUT_W-IN_W){1'b0}}, imm};
            2'b10:   extend = {imm, {(OUT_W-IN_W){1'b0}}};
            default: extend = {sext[OUT_W-3:0], 2'b00};
        endcase
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [OUT_W-1:0] r_main_p1;
    logic [OUT_W-1:0] r_skid_p1;
    logic [OUT_W-1:0] w_ext_p0;
    logic             w_accept;
    logic             w_pop;
    logic             w_load_main;
    logic             w_main_from_skid;
    logic             w_load_skid;

    // Stage p0: combinational extension at the input
    assign w_ext_p0 = extend(mode_i, data_i);

    // Ready and valid decode only the registered state, so no input reaches them.
    assign in_ready_o  = (r_state != ST_FULL);
    assign out_valid_o = (r_state != ST_EMPTY);
    assign data_o      = r_main_p1;

    assign w_accept = in_valid_i & in_ready_o;
    assign w_pop    = out_valid_o & out_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush_i) begin
            // Flush wins over accept and pop; data registers simply hold.
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ST_ONE;
                        w_load_main = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && !w_pop) begin
                        w_state_nxt = ST_FULL;
                        w_load_skid = 1'b1;
                    end else if (w_pop && !w_accept) begin
                        w_state_nxt = ST_EMPTY;
                    end else if (w_accept && w_pop) begin
                        w_load_main = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        w_state_nxt      = ST_ONE;
                        w_load_main      = 1'b1;
                        w_main_from_skid = 1'b1;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Stage p1: main (output) and skid registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_main_p1 <= '0;
            r_skid_p1 <= '0;
        end else begin
            if (w_load_main) begin
                r_main_p1 <= w_main_from_skid ? r_skid_p1 : w_ext_p0;
            end
            if (w_load_skid) begin
                r_skid_p1 <= w_ext_p0;
            end
        end
    end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_imm_ext_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [15:0] din = 16'h0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] dout;

    logic        s_flush = 1'b0;
    logic        s_in_valid = 1'b0;
    logic        s_out_ready = 1'b1;
    logic [1:0]  s_mode = 2'b00;
    logic [7:0]  s_din = 8'h0;
    logic        s_in_ready;
    logic        s_out_valid;
    logic [15:0] s_dout;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [31:0] mq[$];
    bit          m_pop;
    bit          m_acc;

    logic [31:0] exp1 [4] = '{32'hFFFF8001, 32'h00008001, 32'h80010000, 32'hFFFE0004};

    imm_ext_pipe #(.IN_W(16), .OUT_W(32)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .mode_i(mode), .data_i(din),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .data_o(dout)
    );

    imm_ext_pipe #(.IN_W(8), .OUT_W(16)) dut_s (
        .clk_i(clk), .rst_i(rst), .flush_i(s_flush),
        .in_valid_i(s_in_valid), .in_ready_o(s_in_ready),
        .mode_i(s_mode), .data_i(s_din),
        .out_valid_o(s_out_valid), .out_ready_i(s_out_ready), .data_o(s_dout)
    );

    always #5 clk = ~clk;

    // Reference extension from plain integer arithmetic.
    function automatic longint unsigned ref_ext(int inw, int outw, int m, longint unsigned d);
        longint          sv;
        longint unsigned mask;
        mask = (64'd1 << outw) - 64'd1;
        if (d >= (64'd1 << (inw - 1))) sv = longint'(d) - (longint'(1) << inw);
        else sv = longint'(d);
        case (m)
            0:       return $unsigned(sv) & mask;
            1:       return d;
            2:       return (d << (outw - inw)) & mask;
            default: return $unsigned(sv * 4) & mask;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [15:0] d);
        in_valid = v;
        mode     = m;
        din      = d;
    endtask

    // Model: the stage is a FIFO of capacity 2.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
        end else begin
            m_pop = (mq.size() > 0) && out_ready;
            m_acc = in_valid && (mq.size() < 2);
            if (flush) begin
                mq.delete();
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_acc) mq.push_back(32'(ref_ext(16, 32, int'(mode), 64'(din))));
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("model_out_valid", 64'(out_valid), 64'(mq.size() > 0));
            check("model_in_ready", 64'(in_ready), 64'(mq.size() < 2));
            if (mq.size() > 0) check("model_data_o", 64'(dout), 64'(mq[0]));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int  vcnt;
        bit  hold;
        // Reset state
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_data_o", 64'(dout), 64'd0);
        check("rst_small_data_o", 64'(s_dout), 64'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Four modes on 16'h8001
        out_ready = 1'b1;
        vcnt = 0;
        for (int m = 0; m < 4; m++) begin
            drive(1'b1, 2'(m), 16'h8001);
            tick;
            if (out_valid) vcnt++;
            check("t1_data_o", 64'(dout), 64'(exp1[m]));
            check("t1_model_pin", ref_ext(16, 32, m, 64'h8001), 64'(exp1[m]));
        end
        in_valid = 1'b0;
        repeat (3) begin
            tick;
            if (out_valid) vcnt++;
        end
        check("t1_valid_cycles", 64'(vcnt), 64'd4);

        // Backpressure fills the skid
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 16'h0005);
        tick;
        check("t2_first", 64'(dout), 64'h5);
        drive(1'b1, 2'b01, 16'h7FFF);
        tick;
        check("t2_full_in_ready", 64'(in_ready), 64'd0);
        check("t2_full_data", 64'(dout), 64'h5);
        in_valid = 1'b0;
        tick;
        check("t2_stall_data", 64'(dout), 64'h5);
        check("t2_stall_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        tick;
        check("t2_second", 64'(dout), 64'h7FFF);
        check("t2_in_ready_back", 64'(in_ready), 64'd1);
        tick;
        check("t2_drained", 64'(out_valid), 64'd0);

        // Streaming branch offsets at one per cycle
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'b11, 16'(i));
            tick;
            check("t3_stream_data", 64'(dout), 64'(i * 4));
            check("t3_stream_ready", 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        tick;

        // Flush while FULL with a pending input
        out_ready = 1'b0;
        drive(1'b1, 2'b01, 16'h0001);
        tick;
        drive(1'b1, 2'b01, 16'h0002);
        tick;
        check("t4_full", 64'(in_ready), 64'd0);
        drive(1'b1, 2'b01, 16'h1234);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        in_valid = 1'b0;
        check("t4_flush_valid", 64'(out_valid), 64'd0);
        check("t4_flush_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (3) begin
            tick;
            check("t4_post_flush_valid", 64'(out_valid), 64'd0);
        end

        // Asynchronous reset while FULL
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 16'h0003);
        tick;
        drive(1'b1, 2'b00, 16'h0004);
        tick;
        in_valid = 1'b0;
        check("t5_full", 64'(in_ready), 64'd0);
        #2 rst = 1'b1;
        #1;
        check("t5_async_valid", 64'(out_valid), 64'd0);
        check("t5_async_data", 64'(dout), 64'd0);
        check("t5_async_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        tick;
        check("t5_after_reset", 64'(out_valid), 64'd0);

        // Narrow instance
        s_in_valid = 1'b1;
        s_mode = 2'b00;
        s_din = 8'hF0;
        tick;
        check("t6_small_sign", 64'(s_dout), 64'hFFF0);
        check("t6_small_model_pin", ref_ext(8, 16, 0, 64'hF0), 64'hFFF0);
        s_mode = 2'b10;
        tick;
        check("t6_small_upper", 64'(s_dout), 64'hF000);
        s_in_valid = 1'b0;

        // Randomized traffic
        hold = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (!hold) begin
                in_valid = ($urandom_range(0, 9) < 7);
                mode = 2'($urandom_range(0, 3));
                case ($urandom_range(0, 5))
                    0:       din = 16'h8000;
                    1:       din = 16'h7FFF;
                    2:       din = 16'hFFFF;
                    3:       din = 16'h0000;
                    default: din = 16'($urandom);
                endcase
            end
            out_ready = ($urandom_range(0, 9) < 6);
            flush = ($urandom_range(0, 99) < 3);
            hold = in_valid && (mq.size() >= 2);
            tick;
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick;
        check("final_drained", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
